// File: rtl/li_addi_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the 8-bit li/addi datapath.
// Optional feature macro: RETIRE_COUNT_EN (adds the retire_count output).
module li_addi_sequencer #(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ready,
   input  logic [15:0]         imem_rdata,
   output logic                alu_src,
   output logic [1:0]          rs_addr,
   output logic [1:0]          rd_addr,
   output logic [7:0]          imm_data,
   output logic                reg_we,
   output logic                busy,
   output logic                halted
`ifdef RETIRE_COUNT_EN
   ,
   output logic [15:0]         retire_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [1:0]          OP_LI   = 2'b00;
   localparam logic [1:0]          OP_ADDI = 2'b01;
   localparam logic [1:0]          OP_HALT = 2'b11;
   localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   state_t              r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [15:0]         r_ir;
   logic                r_imem_req;
   logic                r_reg_we;
   logic                r_busy;
   logic                r_halted;
`ifdef RETIRE_COUNT_EN
   logic [15:0]         r_retire_count;
`endif

   logic [1:0] w_opcode;
   logic       w_writes;
   logic       w_unused_ir;

   assign w_opcode    = r_ir[15:14];
   assign w_writes    = (w_opcode == OP_LI) || (w_opcode == OP_ADDI);
   // ir[9:8] carries no meaning in this instruction format.
   assign w_unused_ir = &{1'b0, r_ir[9:8]};

   // Sequencer state, pc, instruction register and registered control outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_ir       <= 16'h0000;
         r_imem_req <= 1'b0;
         r_reg_we   <= 1'b0;
         r_busy     <= 1'b0;
         r_halted   <= 1'b0;
`ifdef RETIRE_COUNT_EN
         r_retire_count <= 16'h0000;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  r_state    <= S_FETCH;
                  r_pc       <= RESET_PC;
                  r_imem_req <= 1'b1;
                  r_busy     <= 1'b1;
                  r_halted   <= 1'b0;
`ifdef RETIRE_COUNT_EN
                  r_retire_count <= 16'h0000;
`endif
               end else begin
                  r_state <= r_state;
               end
            end
            S_FETCH: begin
               if (imem_ready) begin
                  r_ir       <= imem_rdata;
                  r_state    <= S_DECODE;
                  r_imem_req <= 1'b0;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            S_DECODE: begin
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_state  <= S_WB;
               r_reg_we <= w_writes;
            end
            S_WB: begin
               r_reg_we <= 1'b0;
               r_pc     <= r_pc + PC_ONE;
`ifdef RETIRE_COUNT_EN
               r_retire_count <= r_retire_count + 16'd1;
`endif
               if (w_opcode == OP_HALT) begin
                  r_state  <= S_HALT;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end else begin
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_imem_req <= 1'b0;
               r_reg_we   <= 1'b0;
               r_busy     <= 1'b0;
               r_halted   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = r_imem_req;
   assign imem_addr = r_pc;
   assign reg_we    = r_reg_we;
   assign busy      = r_busy;
   assign halted    = r_halted;
   assign alu_src   = (w_opcode == OP_ADDI);
   assign rd_addr   = r_ir[13:12];
   assign rs_addr   = r_ir[11:10];
   assign imm_data  = r_ir[7:0];
`ifdef RETIRE_COUNT_EN
   assign retire_count = r_retire_count;
`endif

endmodule

// File: tb/tb_li_addi_sequencer.sv
// Self-checking bench for li_addi_sequencer: instruction-memory model plus write-back scoreboard.
// Build with RETIRE_COUNT_EN defined to also exercise the retire counter.
module tb_li_addi_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic        alu_src;
   logic [1:0]  rs_addr;
   logic [1:0]  rd_addr;
   logic [7:0]  imm_data;
   logic        reg_we;
   logic        busy;
   logic        halted;
`ifdef RETIRE_COUNT_EN
   logic [15:0] retire_count;
`endif

   int n_vec       = 0;
   int n_err       = 0;
   int we_count    = 0;
   int wait_cycles = 0;
   int wcnt        = 0;
   int we_before   = 0;
   int exp_we      = 0;

   logic [15:0] prog [256];
   logic [12:0] sb_q [$];

   always #5 clk = ~clk;

   li_addi_sequencer #(
      .PC_WIDTH (8),
      .RESET_PC (8'd0)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .alu_src    (alu_src),
      .rs_addr    (rs_addr),
      .rd_addr    (rd_addr),
      .imm_data   (imm_data),
      .reg_we     (reg_we),
      .busy       (busy),
      .halted     (halted)
`ifdef RETIRE_COUNT_EN
      ,
      .retire_count (retire_count)
`endif
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at the falling edge of the first FETCH cycle.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halted(input int budget, input string tag);
      int i;
      i = 0;
      while (halted !== 1'b1 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check_value(tag, {31'd0, halted}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_req"},    {31'd0, imem_req}, 32'd0);
      check_value({tag, "_we"},     {31'd0, reg_we},   32'd0);
      check_value({tag, "_busy"},   {31'd0, busy},     32'd0);
      check_value({tag, "_halted"}, {31'd0, halted},   32'd0);
      check_value({tag, "_alu"},    {31'd0, alu_src},  32'd0);
      check_value({tag, "_rs"},     {30'd0, rs_addr},  32'd0);
      check_value({tag, "_rd"},     {30'd0, rd_addr},  32'd0);
      check_value({tag, "_imm"},    {24'd0, imm_data}, 32'd0);
      check_value({tag, "_addr"},   {24'd0, imem_addr}, 32'd0);
   endtask

   // Instruction memory: answers after wait_cycles stalls and queues expected write-backs.
   initial begin
      imem_ready = 1'b0;
      imem_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         if (imem_req === 1'b1) begin
            if (wcnt >= wait_cycles) begin
               if (imem_ready !== 1'b1) begin
                  imem_rdata = prog[imem_addr];
                  imem_ready = 1'b1;
                  if (imem_rdata[15] == 1'b0)
                     sb_q.push_back({imem_rdata[13:12], imem_rdata[11:10],
                                     (imem_rdata[15:14] == 2'b01), imem_rdata[7:0]});
               end
            end else begin
               imem_ready = 1'b0;
               wcnt++;
            end
         end else begin
            imem_ready = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Write-back monitor: every reg_we pulse must match the oldest queued li/addi.
   initial begin
      logic [12:0] exp_wb;
      forever begin
         @(negedge clk);
         if (reg_we === 1'b1) begin
            we_count++;
            check_value("sb_pending", {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
               exp_wb = sb_q.pop_front();
               check_value("wb_decode", {19'd0, rd_addr, rs_addr, alu_src, imm_data}, {19'd0, exp_wb});
            end
         end
      end
   end

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 256; i++) prog[i] = 16'h8000;
      #2 rst_n = 1'b0;
      tick(2);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick(2);
      check_value("idle_busy", {31'd0, busy}, 32'd0);

      // li r1,5 then halt, no memory wait
      prog[0] = 16'h1005;
      prog[1] = 16'hC000;
      wait_cycles = 0;
      pulse_start();
      check_value("li_req",  {31'd0, imem_req}, 32'd1);
      check_value("li_addr", {24'd0, imem_addr}, 32'd0);
      check_value("li_busy", {31'd0, busy}, 32'd1);
      tick(3);
      check_value("li_we",   {31'd0, reg_we}, 32'd1);
      check_value("li_rd",   {30'd0, rd_addr}, 32'd1);
      check_value("li_alu",  {31'd0, alu_src}, 32'd0);
      check_value("li_imm",  {24'd0, imm_data}, 32'h05);
      tick(5);
      check_value("li_halted", {31'd0, halted}, 32'd1);
      check_value("li_busy_end", {31'd0, busy}, 32'd0);
      check_value("li_pc_end", {24'd0, imem_addr}, 32'd2);

      // addi r1,r1,3 with two wait cycles
      prog[0] = 16'h5403;
      wait_cycles = 2;
      pulse_start();
      for (int c = 0; c < 3; c++) begin
         check_value("addi_req_hold",  {31'd0, imem_req}, 32'd1);
         check_value("addi_addr_hold", {24'd0, imem_addr}, 32'd0);
         if (c < 2) tick(1);
      end
      tick(1);
      check_value("addi_req_drop", {31'd0, imem_req}, 32'd0);
      tick(2);
      check_value("addi_we",  {31'd0, reg_we}, 32'd1);
      check_value("addi_alu", {31'd0, alu_src}, 32'd1);
      check_value("addi_rs",  {30'd0, rs_addr}, 32'd1);
      check_value("addi_rd",  {30'd0, rd_addr}, 32'd1);
      check_value("addi_imm", {24'd0, imm_data}, 32'h03);
      wait_halted(30, "addi_halted");
      check_value("addi_pc_end", {24'd0, imem_addr}, 32'd2);

      // nop, halt; a start pulse mid-execution must be ignored
      prog[0] = 16'h8000;
      wait_cycles = 0;
      we_before = we_count;
      pulse_start();
      tick(1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(6);
      check_value("nop_halted", {31'd0, halted}, 32'd1);
      check_value("nop_pc_end", {24'd0, imem_addr}, 32'd2);
      tick(2);
      check_value("nop_no_we", we_count, we_before);

      // pc wraps 255 -> 0
      prog[1] = 16'h8000;
      pulse_start();
      begin
         int i;
         i = 0;
         while (!(imem_req === 1'b1 && imem_addr === 8'd255) && i < 1100) begin
            tick(1);
            i++;
         end
         check_value("wrap_reach", {24'd0, imem_addr}, 32'd255);
         prog[0] = 16'hC000;
         i = 0;
         while (!(imem_req === 1'b1 && imem_addr !== 8'd255) && i < 10) begin
            tick(1);
            i++;
         end
         check_value("wrap_addr", {24'd0, imem_addr}, 32'd0);
      end
      wait_halted(30, "wrap_halted");
      check_value("wrap_pc_end", {24'd0, imem_addr}, 32'd1);

      // reset asserted during EXEC of an li
      prog[0] = 16'h1005;
      prog[1] = 16'hC000;
      we_before = we_count;
      pulse_start();
      tick(2);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      tick(1);
      rst_n = 1'b1;
      tick(5);
      check_value("abort_idle_busy", {31'd0, busy}, 32'd0);
      check_value("abort_no_we", we_count, we_before);
      check_value("abort_pending", sb_q.size(), 32'd1);
      sb_q.delete();
`ifdef RETIRE_COUNT_EN
      check_value("abort_count", {16'd0, retire_count}, 32'd0);
`endif

      // li r2,0xAA; addi r3,r2,0x55; halt with one wait cycle per fetch
      prog[0] = 16'h20AA;
      prog[1] = 16'h7855;
      prog[2] = 16'hC000;
      wait_cycles = 1;
      pulse_start();
      wait_halted(60, "prog_halted");
      check_value("prog_pc_end", {24'd0, imem_addr}, 32'd3);
      exp_we = 4;
`ifdef RETIRE_COUNT_EN
      check_value("retire_3", {16'd0, retire_count}, 32'd3);
      pulse_start();
      check_value("retire_clear", {16'd0, retire_count}, 32'd0);
      wait_halted(60, "retire_rerun_halted");
      check_value("retire_rerun", {16'd0, retire_count}, 32'd3);
      exp_we = 6;
`endif
      tick(2);
      check_value("we_total", we_count, exp_we);
      check_value("sb_leftover", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
